// File: rtl/cdb_arbiter_pkg.sv
// Purpose : shared types, default widths and source ids for the CDB arbiter slice.
// Latency : n/a (declarations only).
// Backpressure : n/a. Ports: none. Build option CDB_FIXED_PRIO_EN is consumed by the arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC   = 2;
  localparam int CDB_DATA_W    = 32;
  localparam int CDB_ROB_IDX_W = 4;

  // Well-known execution-unit slots on the bus.
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;

  localparam bit CDB_TRUE  = 1'b1;
  localparam bit CDB_FALSE = 1'b0;

  typedef logic [CDB_DATA_W-1:0]    data_t;
  typedef logic [CDB_ROB_IDX_W-1:0] rob_idx_t;

  // Candidate index k steps after ptr, wrapping modulo n.
  function automatic int rr_next(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Purpose : source push handshake plus registered CDB broadcast, bundled as one port.
// Latency : n/a (wires only).
// Backpressure : src_ready per source; the broadcast side has none (consumers gate with rdy).
// Ports   : src_valid/src_result/src_rob_index (packed per source), src_ready,
//           cdb_valid/cdb_result/cdb_rob_index/cdb_src. master = execution units, slave = arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = CDB_NUM_SRC,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*DATA_W-1:0]    src_result;
  logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_index;
  logic [NUM_SRC-1:0]           src_ready;

  logic                         cdb_valid;
  logic [DATA_W-1:0]            cdb_result;
  logic [ROB_IDX_W-1:0]         cdb_rob_index;
  logic [IDX_W-1:0]             cdb_src;

  modport master (
    output src_valid, src_result, src_rob_index,
    input  src_ready, cdb_valid, cdb_result, cdb_rob_index, cdb_src
  );

  modport slave (
    input  src_valid, src_result, src_rob_index,
    output src_ready, cdb_valid, cdb_result, cdb_rob_index, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Purpose : picks one requester; round-robin after ptr_i, or lowest index when CDB_FIXED_PRIO_EN.
// Latency : combinational.
// Backpressure : none; at most one grant. Ports: req_i, ptr_i -> gnt_o (one-hot), gnt_idx_o, gnt_vld_o.
module cdb_arbiter_rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_SRC = CDB_NUM_SRC,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [IDX_W-1:0] cand;

`ifdef CDB_FIXED_PRIO_EN
  // Pointer is irrelevant under strict priority.
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
`ifdef CDB_FIXED_PRIO_EN
    // Scan downwards so the last hit (lowest index) wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = IDX_W'(k);
      if (req_i[cand]) begin
        gnt_idx_o = cand;
        gnt_vld_o = 1'b1;
      end
    end
`else
    // Scan from furthest to nearest after the pointer; the nearest hit wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = IDX_W'(rr_next(int'(ptr_i), k, NUM_SRC));
      if (req_i[cand]) begin
        gnt_idx_o = cand;
        gnt_vld_o = 1'b1;
      end
    end
`endif
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Purpose : per-source 1-entry slots feeding one registered CDB broadcast (CDB_FIXED_PRIO_EN = strict prio).
// Latency : push accepted at edge E0 -> cdb_valid after E1; no bypass.
// Backpressure : src_ready = rdy & !clr & (slot empty | slot granted now); rdy low freezes everything.
// Ports   : clk_in, rst_n_in (sync, active-low), rdy_in, clr_in, bus (cdb_arbiter_if.slave).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = CDB_NUM_SRC,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int ROB_IDX_W = CDB_ROB_IDX_W
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  cdb_arbiter_if.slave  bus
);

  localparam int               IDX_W   = $clog2(NUM_SRC);
  // Pointer parked on the last source so source 0 is searched first.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]   slot_vld_q, slot_vld_d;
  logic [DATA_W-1:0]    slot_res_q [NUM_SRC];
  logic [DATA_W-1:0]    slot_res_d [NUM_SRC];
  logic [ROB_IDX_W-1:0] slot_tag_q [NUM_SRC];
  logic [ROB_IDX_W-1:0] slot_tag_d [NUM_SRC];
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 cdb_vld_q, cdb_vld_d;
  logic [DATA_W-1:0]    cdb_res_q, cdb_res_d;
  logic [ROB_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [IDX_W-1:0]     cdb_src_q, cdb_src_d;

  logic [NUM_SRC-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [NUM_SRC-1:0]   src_rdy;
  logic [NUM_SRC-1:0]   accept;

  cdb_arbiter_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req_i     (slot_vld_q),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // A slot being drained this cycle can take a new entry at the same edge.
  assign src_rdy = {NUM_SRC{rdy_in && !clr_in}} & (~slot_vld_q | gnt);
  assign accept  = bus.src_valid & src_rdy;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_res_d = slot_res_q;
    slot_tag_d = slot_tag_q;
    ptr_d      = ptr_q;
    cdb_vld_d  = cdb_vld_q;
    cdb_res_d  = cdb_res_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_src_d  = cdb_src_q;
    if (clr_in) begin
      slot_vld_d = '0;
      cdb_vld_d  = 1'b0;
      ptr_d      = PTR_RST;
    end else if (rdy_in) begin
      cdb_vld_d = gnt_vld;
      if (gnt_vld) begin
        cdb_res_d = slot_res_q[gnt_idx];
        cdb_tag_d = slot_tag_q[gnt_idx];
        cdb_src_d = gnt_idx;
`ifndef CDB_FIXED_PRIO_EN
        ptr_d     = gnt_idx;
`endif
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gnt[i]) slot_vld_d[i] = 1'b0;
        if (accept[i]) begin
          // Tag 0 completes the handshake but leaves the slot empty.
          slot_vld_d[i] = |bus.src_rob_index[i*ROB_IDX_W +: ROB_IDX_W];
          slot_res_d[i] = bus.src_result[i*DATA_W +: DATA_W];
          slot_tag_d[i] = bus.src_rob_index[i*ROB_IDX_W +: ROB_IDX_W];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      slot_vld_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_res_q[i] <= '0;
        slot_tag_q[i] <= '0;
      end
      ptr_q     <= PTR_RST;
      cdb_vld_q <= 1'b0;
      cdb_res_q <= '0;
      cdb_tag_q <= '0;
      cdb_src_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_res_q <= slot_res_d;
      slot_tag_q <= slot_tag_d;
      ptr_q      <= ptr_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_res_q  <= cdb_res_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign bus.src_ready     = src_rdy;
  assign bus.cdb_valid     = cdb_vld_q;
  assign bus.cdb_result    = cdb_res_q;
  assign bus.cdb_rob_index = cdb_tag_q;
  assign bus.cdb_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : self-checking bench for cdb_arbiter (directed scenarios plus random traffic vs a model).
// Latency : n/a.
// Backpressure : inputs driven 1 time unit after each rising edge, outputs checked before the next.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, clr_in;
  always #5 clk_in = ~clk_in;

  cdb_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .ROB_IDX_W(TW)) bus ();

  cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ROB_IDX_W(TW)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .clr_in   (clr_in),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what each slot holds, where the search starts, what is on the bus.
  bit          m_full [N];
  logic [DW-1:0] m_res [N];
  logic [TW-1:0] m_tag [N];
  int          m_ptr;
  bit          m_cvld;
  logic [DW-1:0] m_cres;
  logic [TW-1:0] m_ctag;
  int          m_csrc;

  function automatic int model_grant();
    int g = -1;
`ifdef CDB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (g < 0 && m_full[k]) g = k;
`else
    for (int k = 1; k <= N; k++) if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
`endif
    return g;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g = model_grant();
    for (int k = 0; k < N; k++) r[k] = rdy_in && !clr_in && (!m_full[k] || g == k);
    return r;
  endfunction

  function automatic void model_step();
    int g;
    bit acc [N];
    logic [TW-1:0] t;
    if (!rst_n_in) begin
      for (int k = 0; k < N; k++) m_full[k] = 1'b0;
      m_cvld = 1'b0; m_cres = '0; m_ctag = '0; m_csrc = 0; m_ptr = N - 1;
    end else if (clr_in) begin
      for (int k = 0; k < N; k++) m_full[k] = 1'b0;
      m_cvld = 1'b0; m_ptr = N - 1;
    end else if (rdy_in) begin
      g = model_grant();
      for (int k = 0; k < N; k++) acc[k] = bus.src_valid[k] && (!m_full[k] || g == k);
      m_cvld = (g >= 0);
      if (g >= 0) begin
        m_cres = m_res[g]; m_ctag = m_tag[g]; m_csrc = g; m_full[g] = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
        m_ptr = g;
`endif
      end
      for (int k = 0; k < N; k++) begin
        t = bus.src_rob_index[k*TW +: TW];
        if (acc[k] && t != '0) begin
          m_full[k] = 1'b1; m_res[k] = bus.src_result[k*DW +: DW]; m_tag[k] = t;
        end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input int i, input logic [DW-1:0] r, input logic [TW-1:0] t);
    bus.src_valid[i]              = 1'b1;
    bus.src_result[i*DW +: DW]    = r;
    bus.src_rob_index[i*TW +: TW] = t;
  endtask

  task automatic idle();
    bus.src_valid = '0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; idle();
    tick(); tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.cdb_valid); end
    total++; if (bus.cdb_result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.cdb_result); end
    total++; if (bus.cdb_rob_index !== '0) begin bad++; $display("FAIL reset_tag got=%h exp=0", bus.cdb_rob_index); end
    total++; if (bus.cdb_src !== '0) begin bad++; $display("FAIL reset_src got=%h exp=0", bus.cdb_src); end
    rst_n_in = 1'b1; #1;
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", bus.src_ready); end
  endtask

  task automatic test_single();
    push(CDB_SRC_ALU, 32'h1234, 4'd5); #1;
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL single_ready0 got=%b exp=11", bus.src_ready); end
    tick(); idle(); #1;
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", bus.cdb_valid); end
    // Slot 0 is full but being granted, so it still takes a push.
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL single_ready1 got=%b exp=11", bus.src_ready); end
    tick();
    total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_result !== 32'h1234 || bus.cdb_rob_index !== 4'd5 || bus.cdb_src !== 1'(CDB_SRC_ALU)) begin
      bad++; $display("FAIL single_bcast got=%b/%h/%h/%h exp=1/00001234/5/0", bus.cdb_valid, bus.cdb_result, bus.cdb_rob_index, bus.cdb_src);
    end
    tick();
    total++; if (bus.cdb_valid !== 1'b0 || bus.cdb_result !== 32'h1234) begin
      bad++; $display("FAIL single_after got=%b/%h exp=0/00001234", bus.cdb_valid, bus.cdb_result);
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] bc_q[$];
    logic [N-1:0] er;
    bit prev_vld = 1'b0;
    logic prev_src = 1'b0;
    int errs = 0;
    int c;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        for (int i = 0; i < N; i++) push(i, 32'hC000_0000 + DW'(cyc*2 + i), TW'(1 + (cyc*2 + i) % 15));
      end else idle();
      #1;
      er = model_ready();
      total++; if (bus.src_ready !== er) begin bad++; $display("FAIL cont_ready cyc=%0d got=%b exp=%b", cyc, bus.src_ready, er); end
      for (int i = 0; i < N; i++) if (bus.src_valid[i] && bus.src_ready[i]) acc_q.push_back(bus.src_result[i*DW +: DW]);
      tick();
      total++; if (bus.cdb_valid !== m_cvld || bus.cdb_result !== m_cres || bus.cdb_rob_index !== m_ctag || bus.cdb_src !== 1'(m_csrc)) begin
        bad++; $display("FAIL cont_bcast cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%0d", cyc, bus.cdb_valid, bus.cdb_result, bus.cdb_rob_index, bus.cdb_src, m_cvld, m_cres, m_ctag, m_csrc);
      end
      if (bus.cdb_valid) bc_q.push_back(bus.cdb_result);
`ifdef CDB_FIXED_PRIO_EN
      if (cyc < 8 && bus.cdb_valid) begin
        total++; if (bus.cdb_src !== 1'b0) begin bad++; $display("FAIL cont_prio cyc=%0d got=%b exp=0", cyc, bus.cdb_src); end
      end
`else
      if (cyc < 8 && bus.cdb_valid && prev_vld) begin
        total++; if (bus.cdb_src === prev_src) begin bad++; $display("FAIL cont_alt cyc=%0d got=%b exp=%b", cyc, bus.cdb_src, ~prev_src); end
      end
`endif
      prev_vld = bus.cdb_valid;
      prev_src = bus.cdb_src;
    end
    if (acc_q.size() != bc_q.size()) errs++;
    foreach (acc_q[a]) begin
      c = 0;
      foreach (bc_q[b]) if (bc_q[b] == acc_q[a]) c++;
      if (c != 1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL cont_lossless accepted=%0d broadcast=%0d errors=%0d", acc_q.size(), bc_q.size(), errs); end
  endtask

  task automatic test_tag0();
    push(CDB_SRC_LSB, 32'hFFFF, 4'd0); #1;
    total++; if (bus.src_ready[1] !== 1'b1) begin bad++; $display("FAIL tag0_ready got=%b exp=1", bus.src_ready[1]); end
    tick(); idle();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL tag0_bcast1 got=%b exp=0", bus.cdb_valid); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL tag0_bcast2 got=%b exp=0", bus.cdb_valid); end
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL tag0_empty got=%b exp=11", bus.src_ready); end
  endtask

  task automatic test_flush();
    // Leave the pointer on source 0 so a missing pointer reset would favour source 1.
    push(0, 32'hA0, 4'd2); tick(); idle(); tick(); tick();
    push(0, 32'hA1, 4'd3); push(1, 32'hB1, 4'd4); tick();
    idle(); push(0, 32'h7777, 4'd7); clr_in = 1'b1; #1;
    total++; if (bus.src_ready !== 2'b00) begin bad++; $display("FAIL flush_ready got=%b exp=00", bus.src_ready); end
    tick(); clr_in = 1'b0; idle(); #1;
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.cdb_valid); end
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL flush_empty got=%b exp=11", bus.src_ready); end
    tick();
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_quiet got=%b exp=0", bus.cdb_valid); end
    push(0, 32'hC0, 4'd1); push(1, 32'hD0, 4'd2); tick(); idle(); tick();
    total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 1'b0 || bus.cdb_result !== 32'hC0) begin
      bad++; $display("FAIL flush_ptr0 got=%b/%h/%h exp=1/0/000000c0", bus.cdb_valid, bus.cdb_src, bus.cdb_result);
    end
    tick();
    total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 1'b1 || bus.cdb_result !== 32'hD0) begin
      bad++; $display("FAIL flush_ptr1 got=%b/%h/%h exp=1/1/000000d0", bus.cdb_valid, bus.cdb_src, bus.cdb_result);
    end
  endtask

  task automatic test_freeze();
    int seen = 0;
    push(0, 32'hBEEF, 4'd9); tick(); idle(); rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.src_ready !== 2'b00) begin bad++; $display("FAIL freeze_ready c=%0d got=%b exp=00", c, bus.src_ready); end
      tick();
      total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL freeze_hold c=%0d got=%b exp=0", c, bus.cdb_valid); end
    end
    rdy_in = 1'b1;
    tick();
    total++; if (bus.cdb_valid !== 1'b1 || bus.cdb_result !== 32'hBEEF || bus.cdb_rob_index !== 4'd9) begin
      bad++; $display("FAIL freeze_release got=%b/%h/%h exp=1/0000beef/9", bus.cdb_valid, bus.cdb_result, bus.cdb_rob_index);
    end
    if (bus.cdb_valid && bus.cdb_rob_index == 4'd9) seen++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.cdb_valid && bus.cdb_rob_index == 4'd9) seen++;
    end
    total++; if (seen != 1) begin bad++; $display("FAIL freeze_once got=%0d exp=1", seen); end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clr_in = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        bus.src_valid[i]              = 1'($urandom_range(0, 1));
        bus.src_result[i*DW +: DW]    = DW'($urandom);
        bus.src_rob_index[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom_range(1, 15));
      end
      #1;
      er = model_ready();
      total++; if (bus.src_ready !== er) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.src_ready, er); end
      tick();
      total++; if (bus.cdb_valid !== m_cvld || bus.cdb_result !== m_cres || bus.cdb_rob_index !== m_ctag || bus.cdb_src !== 1'(m_csrc)) begin
        bad++; $display("FAIL rand_bcast cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%0d", cyc, bus.cdb_valid, bus.cdb_result, bus.cdb_rob_index, bus.cdb_src, m_cvld, m_cres, m_ctag, m_csrc);
      end
    end
    rdy_in = 1'b1; clr_in = 1'b0; idle();
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    bus.src_valid = '0; bus.src_result = '0; bus.src_rob_index = '0;
    test_reset();
    test_single();
    test_contention();
    test_tag0();
    test_flush();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
